// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_arbiter_if : fetch, data and memory-side signals of mem_arbiter.
// Rev 1.0
// ============================================================================
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_wr, mem_addr, mem_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_wr, mem_addr, mem_wdata, busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : fetch/data arbiter and fixed-latency sequencer for one memory.
// Optional macro ARB_RR_EN: alternate grants on simultaneous requests. Rev 1.0
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [3:0] c_cnt_init = 4'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              w_i_elig, w_d_elig, w_grant_d, w_issue;
`ifdef ARB_RR_EN
  logic              last_grant_q, last_grant_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef ARB_RR_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
`ifdef ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    // A requester whose ack is showing this cycle sits out one cycle.
    w_i_elig  = bus.i_req && !i_ack_q;
    w_d_elig  = bus.d_req && !d_ack_q;
    w_grant_d = w_d_elig;
`ifdef ARB_RR_EN
    last_grant_d = last_grant_q;
    if (w_i_elig && w_d_elig) begin
      w_grant_d = !last_grant_q;
    end
`endif
    case (state_q)
      IDLE: begin
        if (w_i_elig || w_d_elig) begin
          cnt_d = c_cnt_init;
          if (w_grant_d) begin
            state_d = BUSY_D;
            addr_d  = bus.d_addr;
            wr_d    = bus.d_wr;
            wdata_d = bus.d_wdata;
          end else begin
            state_d = BUSY_I;
            addr_d  = bus.i_addr;
            wr_d    = 1'b0;
            wdata_d = '0;
          end
`ifdef ARB_RR_EN
          last_grant_d = w_grant_d;
`endif
        end
      end
      BUSY_I, BUSY_D: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          if (state_q == BUSY_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = bus.mem_rdata;
          end else begin
            d_ack_d = 1'b1;
            if (!wr_q) begin
              d_rdata_d = bus.mem_rdata;
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The counter only holds its start value in the first BUSY cycle.
  assign w_issue       = (state_q != IDLE) && (cnt_q == c_cnt_init);
  assign bus.mem_en    = w_issue;
  assign bus.mem_wr    = w_issue && wr_q;
  assign bus.mem_addr  = w_issue ? addr_q : '0;
  assign bus.mem_wdata = w_issue ? wdata_q : '0;
  assign bus.busy      = (state_q != IDLE);
  assign bus.i_ack     = i_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : two arbiters (MEM_LAT 4 and 2) on shared stimulus, each with
// a memory model and a cycle model; directed literal checks. Rev 1.0
// ============================================================================
module tb_mem_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic        i_req   = 1'b0;
  logic        d_req   = 1'b0;
  logic        d_wr    = 1'b0;
  logic [15:0] i_addr  = '0;
  logic [15:0] d_addr  = '0;
  logic [15:0] d_wdata = '0;
  int          cyc     = 0;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_lat
    localparam int LAT = (k == 0) ? 4 : 2;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    assign bus.i_req   = i_req;
    assign bus.i_addr  = i_addr;
    assign bus.d_req   = d_req;
    assign bus.d_wr    = d_wr;
    assign bus.d_addr  = d_addr;
    assign bus.d_wdata = d_wdata;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(LAT)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    // Memory: unwritten words read as addr^C3C3, except 0x0010 = A5A5.
    logic [15:0] mem [logic [15:0]];
    function automatic logic [15:0] rd(input logic [15:0] a);
      if (mem.exists(a)) return mem[a];
      if (a == 16'h0010) return 16'hA5A5;
      return a ^ 16'hC3C3;
    endfunction

    int          mt = -100;
    logic [15:0] ma = '0;
    bit          mp = 1'b0;
    always @(posedge clk) begin
      #2;
      if (bus.mem_en === 1'b1) begin
        mt = cyc;
        ma = bus.mem_addr;
        mp = !bus.mem_wr;
        if (bus.mem_wr) mem[bus.mem_addr] = bus.mem_wdata;
      end
      if (mp && cyc == mt + LAT - 1) begin
        bus.mem_rdata = rd(ma);
        mp = 1'b0;
      end else begin
        bus.mem_rdata = 16'hBAD0 ^ 16'(cyc);
      end
    end

    // Transaction-level model: one job with an issue cycle; ack = issue+LAT.
    bit          m_busy = 1'b0;
    int          m_who  = 0;
    int          m_iss  = 0;
    int          m_ack  = -1;
    int          m_lg   = 0;
    bit          m_wr   = 1'b0;
    logic [15:0] m_a    = '0;
    logic [15:0] m_wd   = '0;
    logic [15:0] m_ird  = '0;
    logic [15:0] m_drd  = '0;
    always @(negedge clk) begin
      bit en_e, ie, de;
      int nack, win;
      if (cyc >= 1) begin
        en_e = m_busy && (cyc == m_iss);
        chk1($sformatf("L%0d busy", LAT), bus.busy, m_busy);
        chk1($sformatf("L%0d mem_en", LAT), bus.mem_en, en_e);
        chk1($sformatf("L%0d mem_wr", LAT), bus.mem_wr, en_e && m_wr);
        chk16($sformatf("L%0d mem_addr", LAT), bus.mem_addr, en_e ? m_a : 16'h0);
        chk16($sformatf("L%0d mem_wdata", LAT), bus.mem_wdata, en_e ? m_wd : 16'h0);
        chk1($sformatf("L%0d i_ack", LAT), bus.i_ack, m_ack == 0);
        chk1($sformatf("L%0d d_ack", LAT), bus.d_ack, m_ack == 1);
        chk16($sformatf("L%0d i_rdata", LAT), bus.i_rdata, m_ird);
        chk16($sformatf("L%0d d_rdata", LAT), bus.d_rdata, m_drd);
        if (rst) begin
          m_busy = 1'b0; m_ack = -1; m_ird = '0; m_drd = '0; m_lg = 0;
        end else begin
          nack = -1;
          if (m_busy) begin
            if (cyc == m_iss + LAT - 1) begin
              if (m_who == 0) m_ird = rd(m_a);
              else if (!m_wr) m_drd = rd(m_a);
              m_busy = 1'b0;
              nack   = m_who;
            end
          end else begin
            ie = i_req && (m_ack != 0);
            de = d_req && (m_ack != 1);
            if (ie || de) begin
              win = de ? 1 : 0;
`ifdef ARB_RR_EN
              if (ie && de) win = (m_lg == 0) ? 1 : 0;
`endif
              m_lg   = win;
              m_busy = 1'b1;
              m_who  = win;
              m_iss  = cyc + 1;
              m_a    = (win == 1) ? d_addr : i_addr;
              m_wr   = (win == 1) ? d_wr : 1'b0;
              m_wd   = (win == 1) ? d_wdata : 16'h0;
            end
          end
          m_ack = nack;
        end
      end
    end
  end

  initial begin
    int ni, nd, first_i;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk1("rst busy", g_lat[0].bus.busy, 1'b0);
    chk1("rst mem_en", g_lat[0].bus.mem_en, 1'b0);
    chk1("rst i_ack", g_lat[0].bus.i_ack, 1'b0);
    chk1("rst d_ack", g_lat[0].bus.d_ack, 1'b0);
    chk16("rst i_rdata", g_lat[0].bus.i_rdata, 16'h0);
    chk16("rst d_rdata", g_lat[0].bus.d_rdata, 16'h0);
    nxt();
    rst = 1'b0;
    repeat (2) nxt();

    // Reset in the middle of a read, then a clean read
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0020;
    for (int k = 0; k <= 16; k++) begin
      if (k == 2) rst = 1'b1;
      if (k == 3) begin rst = 1'b0; d_req = 1'b0; end
      if (k == 10) d_req = 1'b1;
      if (k == 16) d_req = 1'b0;
      @(negedge clk);
      if (k == 2) chk1("midrst busy before", g_lat[0].bus.busy, 1'b1);
      if (k >= 3 && k <= 9) begin
        chk1("midrst busy", g_lat[0].bus.busy, 1'b0);
        chk1("midrst d_ack", g_lat[0].bus.d_ack, 1'b0);
        chk1("midrst mem_en", g_lat[0].bus.mem_en, 1'b0);
      end
      if (k == 11) chk16("midrst reissue addr", g_lat[0].bus.mem_addr, 16'h0020);
      if (k == 15) begin
        chk1("midrst d_ack after", g_lat[0].bus.d_ack, 1'b1);
        chk16("midrst d_rdata", g_lat[0].bus.d_rdata, 16'hC3E3);
      end
      nxt();
    end
    repeat (8) nxt();

    // Single fetch
    i_req = 1'b1; i_addr = 16'h0010;
    for (int k = 0; k <= 6; k++) begin
      if (k == 6) i_req = 1'b0;
      @(negedge clk);
      chk1("fetch mem_en", g_lat[0].bus.mem_en, k == 1);
      chk1("fetch i_ack", g_lat[0].bus.i_ack, k == 5);
      if (k == 1) begin
        chk1("fetch mem_wr", g_lat[0].bus.mem_wr, 1'b0);
        chk16("fetch mem_addr", g_lat[0].bus.mem_addr, 16'h0010);
      end
      if (k == 5) chk16("fetch i_rdata", g_lat[0].bus.i_rdata, 16'hA5A5);
      nxt();
    end
    repeat (8) nxt();

    // Data write; late address/data changes must not leak through
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0100; d_wdata = 16'h1234;
    for (int k = 0; k <= 6; k++) begin
      if (k == 2) begin d_addr = 16'hFFFF; d_wdata = 16'hEEEE; end
      if (k == 6) d_req = 1'b0;
      @(negedge clk);
      chk1("write mem_en", g_lat[0].bus.mem_en, k == 1);
      chk1("write d_ack", g_lat[0].bus.d_ack, k == 5);
      if (k == 1) begin
        chk1("write mem_wr", g_lat[0].bus.mem_wr, 1'b1);
        chk16("write mem_addr", g_lat[0].bus.mem_addr, 16'h0100);
        chk16("write mem_wdata", g_lat[0].bus.mem_wdata, 16'h1234);
      end
      if (k == 5) chk16("write keeps d_rdata", g_lat[0].bus.d_rdata, 16'hC3E3);
      nxt();
    end
    repeat (8) nxt();

    // Read back the written word
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0100;
    for (int k = 0; k <= 6; k++) begin
      if (k == 6) d_req = 1'b0;
      @(negedge clk);
      if (k == 5) chk16("readback d_rdata", g_lat[0].bus.d_rdata, 16'h1234);
      nxt();
    end
    repeat (8) nxt();

    // Conflict: D first, I granted in D's ack cycle
    i_req = 1'b1; i_addr = 16'h0030; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0040;
    for (int k = 0; k <= 11; k++) begin
      if (k == 6) d_req = 1'b0;
      if (k == 11) i_req = 1'b0;
      @(negedge clk);
      chk1("conflict mem_en", g_lat[0].bus.mem_en, k == 1 || k == 6);
      chk1("conflict d_ack", g_lat[0].bus.d_ack, k == 5);
      chk1("conflict i_ack", g_lat[0].bus.i_ack, k == 10);
      if (k == 1) chk16("conflict D addr", g_lat[0].bus.mem_addr, 16'h0040);
      if (k == 6) chk16("conflict I addr", g_lat[0].bus.mem_addr, 16'h0030);
      if (k == 5) chk16("conflict d_rdata", g_lat[0].bus.d_rdata, 16'hC383);
      if (k == 10) chk16("conflict i_rdata", g_lat[0].bus.i_rdata, 16'hC3F3);
      nxt();
    end
    repeat (8) nxt();

    // Held fetch: ack-cycle exclusion gives a 6-cycle period
    i_req = 1'b1; i_addr = 16'h0050; ni = 0;
    for (int k = 0; k <= 18; k++) begin
      if (k == 18) i_req = 1'b0;
      @(negedge clk);
      chk1("held i_ack", g_lat[0].bus.i_ack, k == 5 || k == 11 || k == 17);
      if (g_lat[0].bus.i_ack === 1'b1) ni++;
      nxt();
    end
    n_checks++;
    if (ni != 3) begin
      n_fail++;
      $display("FAIL held ack count: got %0d, expected 3", ni);
    end
    repeat (8) nxt();

    // Both held, MEM_LAT=2 instance, starting from reset
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    repeat (2) nxt();
    i_req = 1'b1; i_addr = 16'h0070; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0060;
    ni = 0; nd = 0; first_i = -1;
    for (int k = 0; k <= 39; k++) begin
      @(negedge clk);
      chk1("both d_ack", g_lat[1].bus.d_ack, (k % 6) == 3);
      chk1("both i_ack", g_lat[1].bus.i_ack, k > 0 && (k % 6) == 0);
      if (g_lat[1].bus.d_ack === 1'b1) nd++;
      if (g_lat[1].bus.i_ack === 1'b1) begin
        ni++;
        if (first_i < 0) first_i = k;
      end
      nxt();
    end
    i_req = 1'b0; d_req = 1'b0;
    n_checks++;
    if (ni != 6 || nd != 7 || first_i != 6) begin
      n_fail++;
      $display("FAIL both ack counts: got i=%0d d=%0d first_i=%0d, expected 6 7 6", ni, nd, first_i);
    end
    repeat (10) nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
